// File: rtl/operand_sequencer.sv
// operand_sequencer
//   Front end for a 3-bit ripple-carry adder. The user enters operand A and
//   then operand B on the slide switches, confirming each with a debounced
//   ENTER press. The module drives the adder inputs and captures the adder's
//   sum and carry into a 4-bit result register for display. Subtraction is
//   done in two's complement by inverting B and forcing carry-in to 1.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   sw[2:0]      operand switches (asynchronous)
//   mode         0 = add, 1 = subtract; sampled when B is captured
//   btn_enter    raw ENTER button (asynchronous, bouncy)
//   btn_clear    raw CLEAR button (asynchronous, not debounced)
//   adder_out    adder sum bits
//   adder_cout   adder carry out
//   op_a         registered operand A to the adder
//   op_b         registered operand B to the adder (inverted when subtracting)
//   c_in         adder carry-in (latched mode)
//   result       captured 4-bit result
//   result_valid high while result holds a completed operation
//   state        current FSM state for LED display

module operand_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw,
    input  logic       mode,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic [2:0] adder_out,
    input  logic       adder_cout,
    output logic [2:0] op_a,
    output logic [2:0] op_b,
    output logic       c_in,
    output logic [3:0] result,
    output logic       result_valid,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        SHOW    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       enter_sync;
    logic [1:0]       clear_sync;
    logic [CNT_W-1:0] deb_cnt;
    logic             deb_level;
    logic             deb_prev;
    logic             enter_pulse;
    logic             clear_s;

    state_t     cur_state, state_next;
    logic [2:0] op_a_next, op_b_next;
    logic       c_in_next;
    logic [3:0] result_next;
    logic       result_valid_next;

    assign clear_s     = clear_sync[1];
    assign enter_pulse = deb_level & ~deb_prev;
    assign state       = cur_state;

    // Input conditioning: two-flop synchronizers for both buttons, and a
    // debouncer on ENTER that only changes its level once the synchronized
    // input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    // Any cycle of agreement restarts the count, so bounce never gets through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enter_sync <= '0;
            clear_sync <= '0;
            deb_cnt    <= '0;
            deb_level  <= 1'b0;
            deb_prev   <= 1'b0;
        end else begin
            enter_sync <= {enter_sync[0], btn_enter};
            clear_sync <= {clear_sync[0], btn_clear};
            deb_prev   <= deb_level;
            if (enter_sync[1] != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level <= enter_sync[1];
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Next-state and datapath register logic. Clear wins over everything in
    // the FSM, including a pending capture in COMPUTE and a coincident ENTER.
    // In subtract mode the adder output carry is inverted so bit 3 reads as
    // a borrow flag (set when A < B).
    always_comb begin
        state_next        = cur_state;
        op_a_next         = op_a;
        op_b_next         = op_b;
        c_in_next         = c_in;
        result_next       = result;
        result_valid_next = result_valid;

        if (clear_s) begin
            state_next        = LOAD_A;
            op_a_next         = '0;
            op_b_next         = '0;
            c_in_next         = 1'b0;
            result_next       = '0;
            result_valid_next = 1'b0;
        end else begin
            case (cur_state)
                LOAD_A: begin
                    if (enter_pulse) begin
                        op_a_next  = sw;
                        state_next = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (enter_pulse) begin
                        c_in_next  = mode;
                        op_b_next  = mode ? ~sw : sw;
                        state_next = COMPUTE;
                    end
                end
                COMPUTE: begin
                    result_next       = c_in ? {~adder_cout, adder_out}
                                             : { adder_cout, adder_out};
                    result_valid_next = 1'b1;
                    state_next        = SHOW;
                end
                SHOW: begin
                    if (enter_pulse) begin
                        result_valid_next = 1'b0;
                        op_a_next         = sw;
                        state_next        = LOAD_B;
                    end
                end
                default: state_next = LOAD_A;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state    <= LOAD_A;
            op_a         <= '0;
            op_b         <= '0;
            c_in         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            cur_state    <= state_next;
            op_a         <= op_a_next;
            op_b         <= op_b_next;
            c_in         <= c_in_next;
            result       <= result_next;
            result_valid <= result_valid_next;
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer
//   Self-checking bench for operand_sequencer with a short debounce window.
//   The 3-bit adder is modelled behaviourally. Directed vectors come from a
//   table of hand-computed results; random operations are checked against
//   arithmetic on the operands (sum, or difference with borrow).

module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sw;
    logic       mode;
    logic       btn_enter;
    logic       btn_clear;
    logic [2:0] adder_out;
    logic       adder_cout;
    logic [2:0] op_a;
    logic [2:0] op_b;
    logic       c_in;
    logic [3:0] result;
    logic       result_valid;
    logic [1:0] state;

    int compared   = 0;
    int mismatched = 0;

    operand_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw(sw),
        .mode(mode),
        .btn_enter(btn_enter),
        .btn_clear(btn_clear),
        .adder_out(adder_out),
        .adder_cout(adder_cout),
        .op_a(op_a),
        .op_b(op_b),
        .c_in(c_in),
        .result(result),
        .result_valid(result_valid),
        .state(state)
    );

    // Behavioural ripple-carry adder: plain 4-bit sum of the three inputs.
    assign {adder_cout, adder_out} = {1'b0, op_a} + {1'b0, op_b} + {3'b000, c_in};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       m;
        logic [2:0] exp_op_b;
        logic [3:0] exp_result;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Press ENTER with the switches at val and hold long enough to debounce,
    // then release and let the debouncer settle low again.
    task automatic pressEnter(input logic [2:0] val, input logic m);
        @(negedge clk);
        sw        = val;
        mode      = m;
        btn_enter = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        btn_enter = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyClear();
        @(negedge clk);
        btn_clear = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        btn_clear = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    // One full operation from LOAD_A with exact-latency checks on the B press:
    // debounced pulse appears 6 edges after the raw press, COMPUTE one edge
    // later, and result_valid one edge after that.
    task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b,
                                 input logic m, input logic [2:0] exp_op_b,
                                 input logic [3:0] exp_result);
        pressEnter(a, 1'b0);
        checkOutput("state_after_A", {6'd0, state}, 8'd1);
        checkOutput("op_a_after_A", {5'd0, op_a}, {5'd0, a});
        sw        = b;
        mode      = m;
        btn_enter = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        checkOutput("state_compute", {6'd0, state}, 8'd2);
        checkOutput("valid_in_compute", {7'd0, result_valid}, 8'd0);
        checkOutput("op_b", {5'd0, op_b}, {5'd0, exp_op_b});
        checkOutput("c_in", {7'd0, c_in}, {7'd0, m});
        @(posedge clk);
        @(negedge clk);
        checkOutput("state_show", {6'd0, state}, 8'd3);
        checkOutput("valid_in_show", {7'd0, result_valid}, 8'd1);
        checkOutput("result", {4'd0, result}, {4'd0, exp_result});
        sw   = ~b;
        mode = ~m;
        repeat (6) @(posedge clk);
        @(negedge clk);
        btn_enter = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkOutput("op_a_hold", {5'd0, op_a}, {5'd0, a});
        checkOutput("op_b_hold", {5'd0, op_b}, {5'd0, exp_op_b});
        checkOutput("result_hold", {4'd0, result}, {4'd0, exp_result});
        checkOutput("state_hold", {6'd0, state}, 8'd3);
    endtask

    initial begin
        logic [2:0] ra, rb;
        logic       rm;
        int         diff;
        logic [3:0] rexp;
        logic [2:0] rexp_b;

        vecs[0] = '{a: 3'd3, b: 3'd4, m: 1'b0, exp_op_b: 3'd4,    exp_result: 4'd7};
        vecs[1] = '{a: 3'd7, b: 3'd7, m: 1'b0, exp_op_b: 3'd7,    exp_result: 4'b1110};
        vecs[2] = '{a: 3'd5, b: 3'd2, m: 1'b1, exp_op_b: 3'b101,  exp_result: 4'b0011};
        vecs[3] = '{a: 3'd2, b: 3'd5, m: 1'b1, exp_op_b: 3'b010,  exp_result: 4'b1101};
        vecs[4] = '{a: 3'd0, b: 3'd0, m: 1'b0, exp_op_b: 3'd0,    exp_result: 4'd0};
        vecs[5] = '{a: 3'd0, b: 3'd1, m: 1'b1, exp_op_b: 3'b110,  exp_result: 4'b1111};
        vecs[6] = '{a: 3'd6, b: 3'd6, m: 1'b1, exp_op_b: 3'b001,  exp_result: 4'b0000};
        vecs[7] = '{a: 3'd7, b: 3'd0, m: 1'b1, exp_op_b: 3'b111,  exp_result: 4'b0111};

        rst_n     = 1'b0;
        sw        = 3'd5;
        mode      = 1'b1;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", {6'd0, state}, 8'd0);
        checkOutput("reset_op_a", {5'd0, op_a}, 8'd0);
        checkOutput("reset_op_b", {5'd0, op_b}, 8'd0);
        checkOutput("reset_c_in", {7'd0, c_in}, 8'd0);
        checkOutput("reset_result", {4'd0, result}, 8'd0);
        checkOutput("reset_valid", {7'd0, result_valid}, 8'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] directed vectors");
        for (int i = 0; i < 8; i++) begin
            applyClear();
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp_op_b,
                          vecs[i].exp_result);
        end

        $display("[TB] chain from SHOW");
        applyClear();
        applyStimulus(3'd3, 3'd4, 1'b0, 3'd4, 4'd7);
        @(negedge clk);
        sw        = 3'd6;
        btn_enter = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        checkOutput("chain_state", {6'd0, state}, 8'd1);
        checkOutput("chain_valid", {7'd0, result_valid}, 8'd0);
        checkOutput("chain_op_a", {5'd0, op_a}, 8'd6);
        checkOutput("chain_result_held", {4'd0, result}, 8'd7);
        btn_enter = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkOutput("chain_state_after_release", {6'd0, state}, 8'd1);

        $display("[TB] bounce");
        applyClear();
        sw = 3'd5;
        for (int i = 0; i < 10; i++) begin
            btn_enter = ~btn_enter;
            repeat (2) @(posedge clk);
            @(negedge clk);
        end
        checkOutput("bounce_no_pulse", {6'd0, state}, 8'd0);
        btn_enter = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("bounce_state", {6'd0, state}, 8'd1);
        checkOutput("bounce_op_a", {5'd0, op_a}, 8'd5);
        btn_enter = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkOutput("bounce_single_pulse", {6'd0, state}, 8'd1);

        $display("[TB] clear during COMPUTE");
        applyClear();
        pressEnter(3'd7, 1'b0);
        sw        = 3'd7;
        mode      = 1'b0;
        btn_enter = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        btn_clear = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("clr_compute_reached", {6'd0, state}, 8'd2);
        @(posedge clk);
        @(negedge clk);
        checkOutput("clr_compute_state", {6'd0, state}, 8'd0);
        checkOutput("clr_compute_result", {4'd0, result}, 8'd0);
        checkOutput("clr_compute_valid", {7'd0, result_valid}, 8'd0);
        checkOutput("clr_compute_op_a", {5'd0, op_a}, 8'd0);
        checkOutput("clr_compute_op_b", {5'd0, op_b}, 8'd0);
        btn_enter = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        btn_clear = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] clear during SHOW");
        applyClear();
        applyStimulus(3'd5, 3'd2, 1'b1, 3'b101, 4'b0011);
        @(negedge clk);
        btn_clear = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("clr_show_before", {6'd0, state}, 8'd3);
        @(posedge clk);
        @(negedge clk);
        checkOutput("clr_show_state", {6'd0, state}, 8'd0);
        checkOutput("clr_show_result", {4'd0, result}, 8'd0);
        checkOutput("clr_show_valid", {7'd0, result_valid}, 8'd0);
        checkOutput("clr_show_c_in", {7'd0, c_in}, 8'd0);
        checkOutput("clr_show_op_b", {5'd0, op_b}, 8'd0);

        $display("[TB] enter while clear held");
        pressEnter(3'd3, 1'b0);
        checkOutput("enter_with_clear_state", {6'd0, state}, 8'd0);
        checkOutput("enter_with_clear_op_a", {5'd0, op_a}, 8'd0);
        btn_clear = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] reset mid LOAD_B");
        applyClear();
        pressEnter(3'd6, 1'b0);
        checkOutput("rst_pre_state", {6'd0, state}, 8'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_state", {6'd0, state}, 8'd0);
        checkOutput("rst_mid_op_a", {5'd0, op_a}, 8'd0);
        checkOutput("rst_mid_op_b", {5'd0, op_b}, 8'd0);
        checkOutput("rst_mid_result", {4'd0, result}, 8'd0);
        checkOutput("rst_mid_valid", {7'd0, result_valid}, 8'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] random operations");
        for (int i = 0; i < 30; i++) begin
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            rm = 1'($urandom_range(0, 1));
            if (rm) begin
                diff   = int'(ra) - int'(rb);
                rexp   = 4'(((diff < 0) ? 8 : 0) + ((diff + 8) % 8));
                rexp_b = 3'(7 - int'(rb));
            end else begin
                rexp   = 4'(int'(ra) + int'(rb));
                rexp_b = rb;
            end
            applyClear();
            applyStimulus(ra, rb, rm, rexp_b, rexp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
